appliance_status_reader: RTL and testbench
==========================================

// Module: appliance_status_reader
// PURPOSE
//  Readback path for the appliance controller. The write side loads fridge, AC and
//  washing-machine settings; this block reads those stored values back out.
//  On request it snapshots one field of one device instance and transmits it as a
//  17-bit serial frame on a single line, so a host can verify stored values.
//  It sits beside the controller top and taps every appliance output bus.
// PARAMETERS
//  CLKS_PER_BIT  4   clk cycles per serial bit (>=1); frame = 17*CLKS_PER_BIT cycles
// PORTS
//  clk         in   1   system clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  rd_req      in   1   read request, sampled only in IDLE
//  dev_sel     in   2   0=fridge 1=AC 2=washing machine 3=invalid
//  dev_num     in   1   instance select: 0=unit 1, 1=unit 2
//  field_sel   in   2   field index within the device (see BEHAVIOUR)
//  auto_scan   in   1   continuous scan enable (used only with STATUS_AUTOSCAN_EN)
//  fridge1_st  in   27  {ice,frc[7:0],fgc[7:0],frt[4:0],fgt[4:0]} of fridge 1
//  fridge2_st  in   27  same layout, fridge 2
//  ac1_st      in   20  {timer,fan,cap,temp}, 5 bits each, AC 1
//  ac2_st      in   20  same layout, AC 2
//  wm1_st      in   20  {cloth,spin,rinse,wash}, 5 bits each, washing machine 1
//  wm2_st      in   20  same layout, washing machine 2
//  tx_out      out  1   serial line, idles high
//  busy        out  1   high while a frame is in flight
//  done        out  1   1-cycle pulse at end of stop bit
//  err         out  1   1-cycle pulse: request rejected (dev_sel=3)
// BEHAVIOUR
//  Reset: tx_out=1, busy=0, done=0, err=0, FSM=IDLE, all counters 0. Reset mid-frame
//   aborts immediately: tx_out returns high with no done pulse.
//  Field map: fridge 0=fgt 1=frt 2=fgc 3=frc. AC 0=temp 1=cap 2=fan 3=timer.
//   WM 0=wash 1=rinse 2=spin 3=cloth. Each field is zero-extended to 8-bit data.
//  Flag bit = ice of the selected fridge; 0 for AC and WM.
//  Frame (order on line): start(0), addr[2:0]={dev_sel,dev_num} LSB first,
//   field_sel LSB first, data[7:0] LSB first, parity, flag, stop(1).
//   Parity is even: the XOR of all 13 addr/field/data bits.
//  FSM IDLE->TX->IDLE.
//   IDLE: on rd_req=1 with dev_sel!=3, latch the request and the selected data/flag
//   at that edge. Next cycle: busy=1, tx_out=start.
//   IDLE: on rd_req=1 with dev_sel=3, pulse err for 1 cycle; stay IDLE; busy stays 0.
//   TX: bit counter 0..16; each bit is held exactly CLKS_PER_BIT cycles.
//   After the last stop cycle: done=1 and busy=0 in the same cycle; return to IDLE.
//   A back-to-back request can be accepted in that same cycle.
//  rd_req while busy is ignored; no queueing. Input buses may change mid-frame
//   without affecting it, because the snapshot is latched at accept.
// CONFIGURATION
//  STATUS_AUTOSCAN_EN defined: while auto_scan=1 and in IDLE, the block self-issues
//   reads in order dev_sel 0..2, dev_num 0..1, field 0..3 (24 frames).
//   The scan wraps from (2,1,3) to (0,0,0). rd_req is ignored while auto_scan=1.
//   Deasserting auto_scan lets the current frame finish and then holds the scan
//   position. Reset clears the position to (0,0,0).
//  Not defined: auto_scan is ignored; only rd_req starts frames.
// TESTING
//  (CLKS_PER_BIT=4.)
//  1. Reset, then idle 20 cycles -> tx_out=1, busy=0, no done/err pulses.
//  2. ac1_st fan=19, rd_req with dev_sel=1 dev_num=0 field=2 ->
//     line 0,0,1,0,0,1,1,1,0,0,1,0,0,0,1,0,1 at 4 clk/bit; done 68 cycles after busy rises.
//  3. fridge2_st frc=8'hA5 ice=1, dev_sel=0 dev_num=1 field=3 ->
//     addr 1,0,0; field 1,1; data 1,0,1,0,0,1,0,1; parity=1; flag=1; stop=1.
//  4. rd_req with dev_sel=3 -> err high exactly 1 cycle; busy=0; tx_out stays 1.
//  5. Change wm1_st and pulse rd_req mid-frame -> the frame is unchanged and the
//     extra request is dropped. Drop rst_n at bit 9 -> tx_out=1 immediately; no done.
//  6. STATUS_AUTOSCAN_EN, auto_scan=1 -> 24 frames with addr/field sequence
//     000/00 .. 101/11, then the 25th frame is 000/00.

Source files
------------

// File: rtl/appliance_status_reader.sv
// Snapshots one field of one appliance instance and sends it as a 17-bit serial frame.
// Optional self-scanning of all 24 fields is enabled by defining STATUS_AUTOSCAN_EN.
module appliance_status_reader #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic [1:0]  dev_sel,
    input  logic        dev_num,
    input  logic [1:0]  field_sel,
    input  logic        auto_scan,
    input  logic [26:0] fridge1_st,
    input  logic [26:0] fridge2_st,
    input  logic [19:0] ac1_st,
    input  logic [19:0] ac2_st,
    input  logic [19:0] wm1_st,
    input  logic [19:0] wm2_st,
    output logic        tx_out,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0] LAST_BIT = 5'd16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_TX   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [16:0]      frame_q, frame_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             req_valid;
    logic [1:0]       req_dev;
    logic             req_num;
    logic [1:0]       req_field;
    logic             accept;
    logic             reject;
    logic             tx_last;

    assign accept  = (state_q == ST_IDLE) && req_valid && (req_dev != 2'd3);
    assign reject  = (state_q == ST_IDLE) && req_valid && (req_dev == 2'd3);
    assign tx_last = (bit_cnt_q == LAST_BIT) && (clk_cnt_q == CNT_MAX);

`ifdef STATUS_AUTOSCAN_EN
    logic [1:0] scan_dev_q, scan_dev_d;
    logic       scan_num_q, scan_num_d;
    logic [1:0] scan_field_q, scan_field_d;

    // While scanning, the scan position replaces the host request entirely.
    always_comb begin
        req_valid = auto_scan ? 1'b1 : rd_req;
        req_dev   = auto_scan ? scan_dev_q : dev_sel;
        req_num   = auto_scan ? scan_num_q : dev_num;
        req_field = auto_scan ? scan_field_q : field_sel;
    end

    always_comb begin
        scan_dev_d   = scan_dev_q;
        scan_num_d   = scan_num_q;
        scan_field_d = scan_field_q;
        if (accept && auto_scan) begin
            scan_field_d = scan_field_q + 2'd1;
            if (scan_field_q == 2'd3) begin
                scan_num_d = ~scan_num_q;
                if (scan_num_q) begin
                    scan_dev_d = (scan_dev_q == 2'd2) ? 2'd0 : scan_dev_q + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_dev_q   <= 2'd0;
            scan_num_q   <= 1'b0;
            scan_field_q <= 2'd0;
        end else begin
            scan_dev_q   <= scan_dev_d;
            scan_num_q   <= scan_num_d;
            scan_field_q <= scan_field_d;
        end
    end
`else
    logic unused_auto_scan;
    assign unused_auto_scan = auto_scan;

    always_comb begin
        req_valid = rd_req;
        req_dev   = dev_sel;
        req_num   = dev_num;
        req_field = field_sel;
    end
`endif

    logic [26:0] fridge_st;
    logic [19:0] five_st;
    logic [7:0]  sel_data;
    logic        sel_flag;
    logic [12:0] payload;

    // AC and washing machine share the four-by-five-bit layout, so one mux serves both.
    always_comb begin
        fridge_st = req_num ? fridge2_st : fridge1_st;
        case (req_dev)
            2'd1:    five_st = req_num ? ac2_st : ac1_st;
            2'd2:    five_st = req_num ? wm2_st : wm1_st;
            default: five_st = 20'd0;
        endcase
        sel_data = 8'd0;
        sel_flag = 1'b0;
        if (req_dev == 2'd0) begin
            sel_flag = fridge_st[26];
            case (req_field)
                2'd0:    sel_data = {3'b000, fridge_st[4:0]};
                2'd1:    sel_data = {3'b000, fridge_st[9:5]};
                2'd2:    sel_data = fridge_st[17:10];
                default: sel_data = fridge_st[25:18];
            endcase
        end else begin
            case (req_field)
                2'd0:    sel_data = {3'b000, five_st[4:0]};
                2'd1:    sel_data = {3'b000, five_st[9:5]};
                2'd2:    sel_data = {3'b000, five_st[14:10]};
                default: sel_data = {3'b000, five_st[19:15]};
            endcase
        end
    end

    assign payload = {sel_data, req_field, req_dev, req_num};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)  state_d = ST_TX;
            ST_TX:   if (tx_last) state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == ST_TX);
        tx_out = (state_q == ST_TX) ? frame_q[bit_cnt_q] : 1'b1;
        done   = done_q;
        err    = err_q;
    end

    // Frame bit i is transmitted i-th; index 0 is the start bit, 16 the stop bit.
    always_comb begin
        frame_d   = frame_q;
        bit_cnt_d = 5'd0;
        clk_cnt_d = '0;
        done_d    = (state_q == ST_TX) && tx_last;
        err_d     = reject;
        if (state_q == ST_IDLE) begin
            if (accept) begin
                frame_d = {1'b1, sel_flag, ^payload, payload, 1'b0};
            end
        end else if (clk_cnt_q == CNT_MAX) begin
            bit_cnt_d = tx_last ? 5'd0 : bit_cnt_q + 5'd1;
        end else begin
            bit_cnt_d = bit_cnt_q;
            clk_cnt_d = clk_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q   <= 17'h1ffff;
            bit_cnt_q <= 5'd0;
            clk_cnt_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
            clk_cnt_q <= clk_cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_appliance_status_reader.sv
// Self-checking bench for appliance_status_reader: fixed frame table, hand-written
// corner sequences and randomized reads against a field-map reference model.
module tb_appliance_status_reader;

   localparam int CPB          = 4;
   localparam int FRAME_CYCLES = 17 * CPB;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd_req = 1'b0;
   logic [1:0]  dev_sel = 2'd0;
   logic        dev_num = 1'b0;
   logic [1:0]  field_sel = 2'd0;
   logic        auto_scan = 1'b0;
   logic [26:0] fridge1_st = '0;
   logic [26:0] fridge2_st = '0;
   logic [19:0] ac1_st = '0;
   logic [19:0] ac2_st = '0;
   logic [19:0] wm1_st = '0;
   logic [19:0] wm2_st = '0;
   logic        tx_out;
   logic        busy;
   logic        done;
   logic        err;

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      logic [1:0]  dev;
      logic        num;
      logic [1:0]  fld;
      logic [0:16] line;
   } vec_t;

   vec_t vecs[5];

   appliance_status_reader #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_req     (rd_req),
      .dev_sel    (dev_sel),
      .dev_num    (dev_num),
      .field_sel  (field_sel),
      .auto_scan  (auto_scan),
      .fridge1_st (fridge1_st),
      .fridge2_st (fridge2_st),
      .ac1_st     (ac1_st),
      .ac2_st     (ac2_st),
      .wm1_st     (wm1_st),
      .wm2_st     (wm2_st),
      .tx_out     (tx_out),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Watchdog so a stuck design can never hang the run
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Expected line built from the field map: bit i of the result is the i-th bit on the line
   function automatic logic [16:0] modelFrame(input int dev, input int num, input int fld);
      int          off[4];
      int          wid[4];
      int          data;
      int          flag;
      int          addr;
      int          bits[$];
      logic [26:0] fr;
      logic [19:0] five;
      logic [16:0] f;
      off = '{0, 5, 10, 18};
      wid = '{5, 5, 8, 8};
      fr = (num != 0) ? fridge2_st : fridge1_st;
      five = (dev == 1) ? ((num != 0) ? ac2_st : ac1_st) : ((num != 0) ? wm2_st : wm1_st);
      if (dev == 0) begin
         data = int'(fr >> off[fld]) & ((1 << wid[fld]) - 1);
         flag = int'(fr[26]);
      end else begin
         data = int'(five >> (5 * fld)) & 31;
         flag = 0;
      end
      addr = dev * 2 + num;
      bits.push_back(0);
      for (int i = 0; i < 3; i++) bits.push_back((addr >> i) & 1);
      for (int i = 0; i < 2; i++) bits.push_back((fld >> i) & 1);
      for (int i = 0; i < 8; i++) bits.push_back((data >> i) & 1);
      bits.push_back(($countones(addr) + $countones(fld) + $countones(data)) % 2);
      bits.push_back(flag);
      bits.push_back(1);
      for (int i = 0; i < 17; i++) f[i] = (bits[i] != 0);
      return f;
   endfunction

   // One comparison: counts it, and reports a FAIL line when it does not match
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
   endtask

   // Presents a one-cycle read request starting at a falling edge
   task automatic applyStimulus(input logic [1:0] dev, input logic num, input logic [1:0] fld);
      dev_sel   = dev;
      dev_num   = num;
      field_sel = fld;
      rd_req    = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
   endtask

   // Starts on the first busy cycle; samples mid-bit until busy falls (bounded)
   task automatic receiveFrame(input bit disturb, output logic [16:0] got, output int len,
                               output logic doneSeen);
      got      = '1;
      len      = 0;
      doneSeen = 1'b0;
      for (int c = 0; c < FRAME_CYCLES + 20; c++) begin
         if (!busy) begin
            len      = c;
            doneSeen = done;
            break;
         end
         if ((c % CPB) == (CPB / 2) && (c / CPB) < 17) got[c / CPB] = tx_out;
         if (disturb && c == 20) begin
            wm1_st  = ~wm1_st;
            dev_sel = 2'd1;
            rd_req  = 1'b1;
         end
         if (disturb && c == 21) rd_req = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic checkRead(input string name, input logic [1:0] dev, input logic num,
                            input logic [1:0] fld, input logic [16:0] expLine, input bit disturb);
      logic [16:0] got;
      int          len;
      logic        dn;
      applyStimulus(dev, num, fld);
      checkOutput({name, "_busy_rise"}, 32'(busy), 32'd1);
      receiveFrame(disturb, got, len, dn);
      checkOutput({name, "_line"}, 32'(got), 32'(expLine));
      checkOutput({name, "_len"}, 32'(len), 32'(FRAME_CYCLES));
      checkOutput({name, "_done"}, 32'(dn), 32'd1);
   endtask

   initial begin
      logic [16:0] expLine;
      logic [16:0] got;
      int          len;
      logic        dn;
      int          bad;
      int          dev;
      int          num;
      int          fld;

      vecs[0] = '{2'd1, 1'b0, 2'd2, 17'b0_010_01_11001000_1_0_1};
      vecs[1] = '{2'd0, 1'b1, 2'd3, 17'b0_100_11_10100101_1_1_1};
      vecs[2] = '{2'd0, 1'b0, 2'd0, 17'b0_000_00_00000000_0_1_1};
      vecs[3] = '{2'd2, 1'b1, 2'd2, 17'b0_101_01_01100000_1_0_1};
      vecs[4] = '{2'd1, 1'b1, 2'd3, 17'b0_110_11_11111000_1_0_1};

      fridge1_st = {1'b1, 26'd0};
      fridge2_st = {1'b1, 8'hA5, 18'd0};
      ac1_st     = 20'd19 << 10;
      ac2_st     = 20'd31 << 15;
      wm1_st     = 20'd0;
      wm2_st     = 20'd6 << 10;

      // Reset and quiet idle
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) bad++;
      end
      checkOutput("reset_idle_quiet", 32'(bad), 32'd0);

      // Fixed frame table
      for (int i = 0; i < 5; i++) begin
         for (int b = 0; b < 17; b++) expLine[b] = vecs[i].line[b];
         checkRead($sformatf("table%0d", i), vecs[i].dev, vecs[i].num, vecs[i].fld, expLine, 1'b0);
         @(negedge clk);
         checkOutput($sformatf("table%0d_done_one_cycle", i), 32'(done), 32'd0);
      end

      // Rejected request
      dev_sel = 2'd3;
      rd_req  = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      checkOutput("err_pulse", 32'(err), 32'd1);
      checkOutput("err_busy", 32'(busy), 32'd0);
      checkOutput("err_tx", 32'(tx_out), 32'd1);
      @(negedge clk);
      checkOutput("err_one_cycle", 32'(err), 32'd0);
      checkOutput("err_still_idle", 32'(busy), 32'd0);

      // Bus change and extra request mid-frame are both ignored
      wm1_st  = 20'($urandom);
      expLine = modelFrame(2, 0, 1);
      checkRead("midframe", 2'd2, 1'b0, 2'd1, expLine, 1'b1);
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (busy !== 1'b0 || tx_out !== 1'b1) bad++;
      end
      checkOutput("midframe_req_dropped", 32'(bad), 32'd0);

      // Back-to-back: request held through a frame is taken again in the done cycle
      dev_sel = 2'd1; dev_num = 1'b0; field_sel = 2'd2; rd_req = 1'b1;
      @(negedge clk);
      receiveFrame(1'b0, got, len, dn);
      checkOutput("b2b_first_line", 32'(got), 32'(modelFrame(1, 0, 2)));
      checkOutput("b2b_first_done", 32'(dn), 32'd1);
      dev_sel = 2'd0; dev_num = 1'b1; field_sel = 2'd3;
      expLine = modelFrame(0, 1, 3);
      @(negedge clk);
      rd_req = 1'b0;
      checkOutput("b2b_no_gap", 32'(busy), 32'd1);
      receiveFrame(1'b0, got, len, dn);
      checkOutput("b2b_second_line", 32'(got), 32'(expLine));
      checkOutput("b2b_second_len", 32'(len), 32'(FRAME_CYCLES));

      // Reset during bit 9 aborts without a done pulse
      @(negedge clk);
      applyStimulus(2'd1, 1'b0, 2'd2);
      repeat (9 * CPB + 1) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_tx_high", 32'(tx_out), 32'd1);
      checkOutput("abort_busy_low", 32'(busy), 32'd0);
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (done !== 1'b0 || tx_out !== 1'b1) bad++;
      end
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0 || tx_out !== 1'b1) bad++;
      end
      checkOutput("abort_no_done", 32'(bad), 32'd0);

      // Randomized reads against the reference model
      for (int k = 0; k < 16; k++) begin
         fridge1_st = 27'($urandom);
         fridge2_st = 27'($urandom);
         ac1_st     = 20'($urandom);
         ac2_st     = 20'($urandom);
         wm1_st     = 20'($urandom);
         wm2_st     = 20'($urandom);
         dev = int'($urandom_range(0, 3));
         num = int'($urandom_range(0, 1));
         fld = int'($urandom_range(0, 3));
         if (dev == 3) begin
            applyStimulus(2'd3, num[0], fld[1:0]);
            checkOutput($sformatf("rand%0d_err", k), 32'(err), 32'd1);
            checkOutput($sformatf("rand%0d_err_busy", k), 32'(busy), 32'd0);
         end else begin
            expLine = modelFrame(dev, num, fld);
            checkRead($sformatf("rand%0d", k), dev[1:0], num[0], fld[1:0], expLine, 1'b0);
         end
         @(negedge clk);
      end

`ifdef STATUS_AUTOSCAN_EN
      // Scan visits all 24 fields and wraps to the first
      auto_scan = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 25; k++) begin
         dev = (k % 24) / 8;
         num = ((k % 24) / 4) % 2;
         fld = k % 4;
         checkOutput($sformatf("scan%0d_busy", k), 32'(busy), 32'd1);
         receiveFrame(1'b0, got, len, dn);
         checkOutput($sformatf("scan%0d_line", k), 32'(got), 32'(modelFrame(dev, num, fld)));
         if (k == 24) auto_scan = 1'b0;
         @(negedge clk);
      end
      checkOutput("scan_stop", 32'(busy), 32'd0);
`else
      // Without the scan feature auto_scan has no effect
      auto_scan = 1'b1;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy !== 1'b0 || tx_out !== 1'b1) bad++;
      end
      auto_scan = 1'b0;
      checkOutput("autoscan_ignored", 32'(bad), 32'd0);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
